mux_operando_ula_reg: RTL and testbench
=======================================

Name: mux_operando_ula_reg

Overview:
Parametrised, registered successor to the ALU operand-B selector. It selects one of NUM_ENTRADAS operand sources, one of which can be a built-in constant (PC+4 increment). The selected value is delivered through a 2-entry valid/ready skid buffer, so the operand path can be pipelined and back-pressured by the ALU stage without losing operands. It sits between the register file/extend/shift units and the ALU B input.

Parameters:
WIDTH, 32, operand width in bits.
NUM_ENTRADAS, 4, number of selectable sources (2..16).
SEL_W, $clog2(NUM_ENTRADAS), selector width (derived; not overridden).
CONST_EN, 1, 1 = slot CONST_INDEX is driven by CONST_VALOR instead of its input.
CONST_INDEX, 1, slot index replaced by the constant.
CONST_VALOR, 4, constant value, zero-extended or truncated to WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
seletor  input  SEL_W  source select, sampled on accept.
entradas  input  NUM_ENTRADAS*WIDTH  flattened sources; slot i = bits [i*WIDTH +: WIDTH].
validoEntrada  input  1  upstream has an operand request this cycle.
prontoEntrada  output  1  block can accept a request.
dadosSaida  output  WIDTH  selected operand.
erroSel  output  1  beat flag: selector was out of range (>= NUM_ENTRADAS).
validoSaida  output  1  dadosSaida/erroSel valid.
prontoSaida  input  1  downstream consumes the beat.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset (asynchronous, effective immediately): state VAZIO, validoSaida=0, dadosSaida=0, erroSel=0, both buffer entries cleared, prontoEntrada=1.
- Accept = validoEntrada & prontoEntrada. Pop = validoSaida & prontoSaida.
- Selection is combinational at accept: slot seletor, or CONST_VALOR if CONST_EN and seletor==CONST_INDEX. Out-of-range seletor gives data 0 and erroSel=1 for that beat. All other beats have erroSel=0.
- Latency: accepted in cycle N, visible on dadosSaida with validoSaida=1 in cycle N+1.
- prontoEntrada = (estado != CHEIO2), decoded from the state register only. No combinational path from prontoSaida.
- States: VAZIO (0 entries), CHEIO1 (main register valid), CHEIO2 (main + skid valid).
  - VAZIO: accept -> CHEIO1, main loaded.
  - CHEIO1: accept & !pop -> CHEIO2, skid loaded. pop & !accept -> VAZIO. accept & pop -> CHEIO1, main reloaded with new beat. Neither -> hold.
  - CHEIO2: pop -> CHEIO1, main <= skid. No accept possible. No pop -> hold.
- While validoSaida=1 and prontoSaida=0, dadosSaida and erroSel are held stable.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Sustained throughput is 1 beat/cycle when prontoSaida is held at 1.
- Unused state encoding -> VAZIO on next clock.
- validoSaida = (estado != VAZIO).
- Inputs are ignored when accept=0. Selector and entradas are sampled only at accept.

Decomposition:
- Shared package (pkg_ula_operandos):
  - state encodings VAZIO/CHEIO1/CHEIO2 (2-bit);
  - default constant CONST_PC_INC = 4;
  - slot-index constants SEL_REGB=0, SEL_QUATRO=1, SEL_SIGNEXT=2, SEL_SHIFT2=3, matching the existing ALU-B selector encoding.
- One sub-module: mux_n_para_1 (parametrised WIDTH/NUM_ENTRADAS, purely combinational, outputs data plus out-of-range flag). The skid buffer and FSM live in the top module.

Test Plan:
1. Assert reset mid-idle, then release -> validoSaida=0, dadosSaida=0, erroSel=0, prontoEntrada=1 immediately at reset assertion.
2. Defaults, prontoSaida=1, validoEntrada=1 for one cycle with seletor=1, entradas slot1=0xDEADBEEF -> next cycle dadosSaida=0x00000004, validoSaida=1, erroSel=0. Repeat with seletor=2, slot2=0xFFFFFFF0 -> 0xFFFFFFF0.
3. prontoSaida=0; push 0x11 (sel 0), then 0x22 (sel 0) -> prontoEntrada=0 after second accept, dadosSaida holds 0x11. Raise prontoSaida -> 0x11 then 0x22 on consecutive cycles, then validoSaida=0.
4. prontoSaida=1; stream 8 back-to-back beats 0x1..0x8 on slot 3 -> outputs 0x1..0x8 in cycles N+1..N+8, prontoEntrada stays 1 throughout.
5. NUM_ENTRADAS=5 (SEL_W=3), seletor=6 -> dadosSaida=0, erroSel=1 one cycle later. Following beat with seletor=4 -> erroSel=0.
6. Fill to CHEIO2 (prontoSaida=0), assert reset asynchronously between clock edges -> validoSaida=0 and prontoEntrada=1 without a clock edge. After release, no stale beat appears.

Source files
------------

// File: rtl/mux_operando_ula_reg_pkg.sv
// Shared definitions for the registered ALU operand-B selector.
package pkg_ula_operandos;

  // Occupancy of the 2-entry output skid buffer.
  typedef enum logic [1:0] {
    VAZIO  = 2'd0,
    CHEIO1 = 2'd1,
    CHEIO2 = 2'd2
  } estado_t;

  // PC increment applied when the constant slot is selected.
  localparam int unsigned CONST_PC_INC = 4;

  // Slot indices of the existing ALU-B selector encoding.
  localparam int unsigned SEL_REGB    = 0;
  localparam int unsigned SEL_QUATRO  = 1;
  localparam int unsigned SEL_SIGNEXT = 2;
  localparam int unsigned SEL_SHIFT2  = 3;

endpackage

// File: rtl/mux_operando_ula_reg_mux.sv
// Combinational N-to-1 selector with an out-of-range flag.
module mux_n_para_1 #(
  parameter int WIDTH        = 32,
  parameter int NUM_ENTRADAS = 4,
  parameter int SEL_W        = $clog2(NUM_ENTRADAS)
) (
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_ENTRADAS*WIDTH-1:0] entradas,
  output logic [WIDTH-1:0]              dados,
  output logic                          fora_faixa
);

  // Pick the matching slot; no match means the selector is out of range.
  always_comb begin
    dados      = '0;
    fora_faixa = 1'b1;
    for (int unsigned i = 0; i < NUM_ENTRADAS; i++) begin
      if (sel == SEL_W'(i)) begin
        dados      = entradas[i*WIDTH +: WIDTH];
        fora_faixa = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_operando_ula_reg.sv
// Registered ALU operand-B selector with a 2-entry valid/ready skid buffer.
module mux_operando_ula_reg
  import pkg_ula_operandos::*;
#(
  parameter int              WIDTH        = 32,
  parameter int              NUM_ENTRADAS = 4,
  parameter int              SEL_W        = $clog2(NUM_ENTRADAS),
  parameter bit              CONST_EN     = 1'b1,
  parameter int unsigned     CONST_INDEX  = SEL_QUATRO,
  parameter longint unsigned CONST_VALOR  = CONST_PC_INC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SEL_W-1:0]              seletor,
  input  logic [NUM_ENTRADAS*WIDTH-1:0] entradas,
  input  logic                          validoEntrada,
  output logic                          prontoEntrada,
  output logic [WIDTH-1:0]              dadosSaida,
  output logic                          erroSel,
  output logic                          validoSaida,
  input  logic                          prontoSaida
);

  localparam logic [WIDTH-1:0] CONST_W     = WIDTH'(CONST_VALOR);
  localparam logic [SEL_W-1:0] CONST_SEL   = SEL_W'(CONST_INDEX);
  localparam bit               CONST_ATIVO = CONST_EN && (CONST_INDEX < NUM_ENTRADAS);

  estado_t          estado, estado_prox;
  logic [WIDTH-1:0] dados_principal, dados_skid;
  logic             erro_principal, erro_skid;

  logic [WIDTH-1:0] dados_mux, dados_sel;
  logic             erro_mux;
  logic             aceita, pop;
  logic             carrega_principal, carrega_skid, move_skid;

  mux_n_para_1 #(
    .WIDTH        (WIDTH),
    .NUM_ENTRADAS (NUM_ENTRADAS),
    .SEL_W        (SEL_W)
  ) u_mux (
    .sel        (seletor),
    .entradas   (entradas),
    .dados      (dados_mux),
    .fora_faixa (erro_mux)
  );

  // Constant slot overrides the mux result when selected.
  always_comb begin
    dados_sel = dados_mux;
    if (CONST_ATIVO && (seletor == CONST_SEL)) dados_sel = CONST_W;
  end

  assign prontoEntrada = (estado != CHEIO2);
  assign validoSaida   = (estado != VAZIO);
  assign aceita        = validoEntrada & prontoEntrada;
  assign pop           = validoSaida & prontoSaida;
  assign dadosSaida    = dados_principal;
  assign erroSel       = erro_principal;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= VAZIO;
    else       estado <= estado_prox;
  end

  // Next state and buffer load controls.
  always_comb begin
    estado_prox       = estado;
    carrega_principal = 1'b0;
    carrega_skid      = 1'b0;
    move_skid         = 1'b0;
    case (estado)
      VAZIO: begin
        if (aceita) begin
          estado_prox       = CHEIO1;
          carrega_principal = 1'b1;
        end
      end
      CHEIO1: begin
        if (aceita && !pop) begin
          estado_prox  = CHEIO2;
          carrega_skid = 1'b1;
        end else if (pop && !aceita) begin
          estado_prox = VAZIO;
        end else if (aceita && pop) begin
          carrega_principal = 1'b1;
        end
      end
      CHEIO2: begin
        if (pop) begin
          estado_prox = CHEIO1;
          move_skid   = 1'b1;
        end
      end
      default: estado_prox = VAZIO;
    endcase
  end

  // Main and skid data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dados_principal <= '0;
      erro_principal  <= 1'b0;
      dados_skid      <= '0;
      erro_skid       <= 1'b0;
    end else begin
      if (carrega_principal) begin
        dados_principal <= dados_sel;
        erro_principal  <= erro_mux;
      end else if (move_skid) begin
        dados_principal <= dados_skid;
        erro_principal  <= erro_skid;
      end
      if (carrega_skid) begin
        dados_skid <= dados_sel;
        erro_skid  <= erro_mux;
      end
    end
  end

endmodule

// File: tb/tb_mux_operando_ula_reg.sv
// Self-checking bench: depth-2 FIFO reference model plus directed/random steps.
module tb_mux_operando_ula_reg;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   seletor = '0;
  logic [127:0] entradas = '0;
  logic         validoEntrada = 1'b0;
  logic         prontoEntrada;
  logic [31:0]  dadosSaida;
  logic         erroSel;
  logic         validoSaida;
  logic         prontoSaida = 1'b1;

  logic [2:0]   sel5 = '0;
  logic [159:0] ent5 = '0;
  logic         v5 = 1'b0;
  logic         pe5;
  logic [31:0]  d5;
  logic         e5;
  logic         vs5;

  int tests = 0;
  int fails = 0;
  logic [32:0] fila[$];

  always #5 clk = ~clk;

  mux_operando_ula_reg dut (
    .clk(clk), .reset(reset), .seletor(seletor), .entradas(entradas),
    .validoEntrada(validoEntrada), .prontoEntrada(prontoEntrada),
    .dadosSaida(dadosSaida), .erroSel(erroSel), .validoSaida(validoSaida),
    .prontoSaida(prontoSaida)
  );

  mux_operando_ula_reg #(.NUM_ENTRADAS(5)) dut5 (
    .clk(clk), .reset(reset), .seletor(sel5), .entradas(ent5),
    .validoEntrada(v5), .prontoEntrada(pe5),
    .dadosSaida(d5), .erroSel(e5), .validoSaida(vs5),
    .prontoSaida(1'b1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference selection: out of range -> error beat, slot 1 -> PC increment.
  function automatic logic [32:0] ref_beat(input int unsigned sel, input logic [159:0] ent,
                                           input int unsigned n);
    if (sel >= n) return {1'b1, 32'h0};
    if (sel == 1) return {1'b0, 32'd4};
    return {1'b0, ent[sel*32 +: 32]};
  endfunction

  // One clock of the main DUT, advancing the FIFO model and checking outputs.
  task automatic ciclo();
    logic acc, pop;
    logic [32:0] b;
    acc = validoEntrada && (fila.size() < 2);
    pop = (fila.size() > 0) && prontoSaida;
    b   = ref_beat(32'(seletor), {32'h0, entradas}, 4);
    @(posedge clk); #1;
    if (pop) void'(fila.pop_front());
    if (acc) fila.push_back(b);
    chk("validoSaida", validoSaida, fila.size() > 0);
    chk("prontoEntrada", prontoEntrada, fila.size() < 2);
    if (fila.size() > 0) begin
      chk("dadosSaida", dadosSaida, fila[0][31:0]);
      chk("erroSel", erroSel, fila[0][32]);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [127:0] e);
    seletor = s; entradas = e; validoEntrada = 1'b1;
    ciclo();
    validoEntrada = 1'b0;
  endtask

  initial begin
    logic [127:0] e;

    // 1: reset mid-idle, outputs cleared immediately
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_valid", validoSaida, 0);
    chk("rst_data", dadosSaida, 0);
    chk("rst_erro", erroSel, 0);
    chk("rst_pronto", prontoEntrada, 1);
    @(negedge clk); reset = 1'b0;
    fila.delete();
    ciclo();

    // 2: constant slot and plain slot
    prontoSaida = 1'b1;
    e = {$urandom, 32'hFFFFFFF0, 32'hDEADBEEF, $urandom};
    push(2'd1, e);
    chk("const_slot", dadosSaida, 32'h4);
    push(2'd2, e);
    chk("slot2", dadosSaida, 32'hFFFFFFF0);
    ciclo();

    // 3: back-pressure fills skid, then drains in order
    prontoSaida = 1'b0;
    push(2'd0, {96'h0, 32'h11});
    push(2'd0, {96'h0, 32'h22});
    chk("full_pronto", prontoEntrada, 0);
    chk("hold_data", dadosSaida, 32'h11);
    ciclo();
    prontoSaida = 1'b1;
    repeat (3) ciclo();
    chk("drained", validoSaida, 0);

    // 4: back-to-back stream at full rate
    for (int i = 1; i <= 8; i++) begin
      push(2'd3, {32'(i), $urandom, $urandom, $urandom});
      chk("stream_pronto", prontoEntrada, 1);
      chk("stream_data", dadosSaida, 32'(i));
    end
    ciclo();

    // 5: out-of-range selector on a 5-slot instance
    ent5 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    sel5 = 3'd6; v5 = 1'b1;
    @(posedge clk); #1;
    chk("oor_valid", vs5, 1);
    chk("oor_data", d5, 0);
    chk("oor_erro", e5, 1);
    sel5 = 3'd4;
    @(posedge clk); #1;
    v5 = 1'b0;
    chk("in_range_erro", e5, 0);
    chk("in_range_data", d5, ent5[159:128]);
    @(posedge clk); #1;
    chk("n5_drained", vs5, 0);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      validoEntrada = 1'($urandom);
      prontoSaida   = ($urandom_range(0, 3) != 0);
      seletor       = 2'($urandom);
      entradas      = {$urandom, $urandom, $urandom, $urandom};
      ciclo();
    end
    validoEntrada = 1'b0;

    // 6: async reset while full, between clock edges
    prontoSaida = 1'b0;
    repeat (3) ciclo();
    push(2'd0, {96'h0, 32'hAA});
    push(2'd2, {64'h0, 32'hBB, 32'h0});
    chk("pre_rst_full", prontoEntrada, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", validoSaida, 0);
    chk("async_pronto", prontoEntrada, 1);
    chk("async_data", dadosSaida, 0);
    fila.delete();
    @(negedge clk); reset = 1'b0;
    prontoSaida = 1'b1;
    repeat (3) ciclo();
    chk("no_stale", validoSaida, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
